// File: rtl/dct_pkg.sv
// Shared widths, FSM states, tag format and Q10 coefficient table for the
// 4-point DCT MAC scheduler.
package dct_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned COEF_W   = 14;
  localparam int unsigned PROD_W   = 22;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned Q_FRAC   = 10;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    FLUSH,
    EMIT
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       first;
    logic       last;
    logic [1:0] k;
  } tag_t;

  // Indexed {row k, column n}; row k produces DCT coefficient k.
  localparam logic signed [COEF_W-1:0] COEF [16] = '{
    14'sd512,  14'sd512,  14'sd512,  14'sd512,
    14'sd669,  14'sd277, -14'sd277, -14'sd669,
    14'sd512, -14'sd512, -14'sd512,  14'sd512,
    14'sd277, -14'sd669,  14'sd669, -14'sd277
  };

endpackage

// File: rtl/dct4_coef_rom.sv
// Combinational coefficient ROM: op index {k, n} to signed Q10 coefficient.
module dct4_coef_rom
  import dct_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [COEF_W-1:0] coef
);

  assign coef = COEF[idx];

endmodule

// File: rtl/dct4_mac_scheduler.sv
// 4-point DCT sequencer sharing one external pipelined multiplier across all
// 16 products. Optional macro DCT_ROUND_EN selects round-half-up scaling.
module dct4_mac_scheduler
  import dct_pkg::*;
#(
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned OUT_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W-1:0]      in_data,
  output logic [SAMPLE_W-1:0]      mult_a,
  output logic [COEF_W-1:0]        mult_b,
  input  logic signed [PROD_W-1:0] mult_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);

`ifdef DCT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (Q_FRAC - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  state_t                   state, state_next;
  logic [3:0]               cnt;
  logic [SAMPLE_W-1:0]      x [4];
  tag_t                     tag_q [MULT_LAT];
  tag_t                     tag_in, tail;
  logic signed [ACC_W-1:0]  acc, acc_next, prod_ext;
  logic signed [OUT_W-1:0]  res [4];
  logic [COEF_W-1:0]        coef;
  logic                     in_hs, out_hs, pending;

  dct4_coef_rom u_rom (
    .idx  (cnt),
    .coef (coef)
  );

  assign in_ready  = (state == LOAD) && !clr;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state == EMIT);
  assign out_hs    = out_valid && out_ready && !clr;
  assign out_idx   = out_valid ? cnt[1:0] : 2'd0;
  assign out_last  = out_valid && (cnt[1:0] == 2'd3);
  assign out_data  = out_valid ? res[cnt[1:0]] : '0;
  assign busy      = (state != LOAD);
  assign mult_a    = (state == COMPUTE) ? x[cnt[1:0]] : '0;
  assign mult_b    = (state == COMPUTE) ? coef : '0;

  // Leave FLUSH on the edge that retires the last tag, so EMIT starts with
  // res[3] already written.
  always_comb begin
    pending = 1'b0;
    for (int unsigned s = 0; s + 1 < MULT_LAT; s++) pending = pending | tag_q[s].valid;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD:    if (in_hs && cnt == 4'd3) state_next = COMPUTE;
        COMPUTE: if (cnt == 4'd15) state_next = FLUSH;
        FLUSH:   if (!pending) state_next = EMIT;
        EMIT:    if (out_hs && cnt[1:0] == 2'd3) state_next = LOAD;
        default: state_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int unsigned j = 0; j < 4; j++) x[j] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      case (state)
        LOAD: if (in_hs) begin
          x[cnt[1:0]] <= in_data;
          cnt         <= (cnt == 4'd3) ? '0 : cnt + 4'd1;
        end
        COMPUTE: cnt <= cnt + 4'd1;
        FLUSH:   cnt <= '0;
        EMIT:    if (out_hs) cnt <= (cnt == 4'd3) ? '0 : cnt + 4'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state == COMPUTE);
    tag_in.first = (cnt[1:0] == 2'd0);
    tag_in.last  = (cnt[1:0] == 2'd3);
    tag_in.k     = cnt[3:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < MULT_LAT; s++) tag_q[s] <= '0;
    end else if (clr) begin
      for (int unsigned s = 0; s < MULT_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned s = 1; s < MULT_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tail     = tag_q[MULT_LAT-1];
  assign prod_ext = {{(ACC_W-PROD_W){mult_p[PROD_W-1]}}, mult_p};
  assign acc_next = tail.first ? prod_ext : acc + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      for (int unsigned j = 0; j < 4; j++) res[j] <= '0;
    end else if (clr) begin
      for (int unsigned j = 0; j < 4; j++) res[j] <= '0;
    end else if (tail.valid) begin
      acc <= acc_next;
      if (tail.last) res[tail.k] <= OUT_W'((acc_next + RND) >>> Q_FRAC);
    end
  end

endmodule

// File: tb/tb_dct4_mac_scheduler.sv
// Scoreboard bench for dct4_mac_scheduler: a pipelined multiplier model feeds
// the DUT, and expected coefficients come from a direct dot-product model.
module tb_dct4_mac_scheduler;

  localparam int unsigned LAT   = 3;
  localparam int unsigned OUT_W = 12;

  logic                    clk = 1'b0;
  logic                    rst_n, clr, in_valid, in_ready;
  logic [7:0]              in_data, mult_a;
  logic [13:0]             mult_b;
  logic signed [21:0]      mult_p;
  logic                    out_valid, out_ready, out_last, busy;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_idx;

  always #5 clk = ~clk;

  dct4_mac_scheduler #(.MULT_LAT(LAT), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct { int data; int idx; } exp_t;

  localparam int C_TB [16] = '{512, 512, 512, 512, 669, 277, -277, -669,
                               512, -512, -512, 512, 277, -669, 669, -277};

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0, errors = 0;
  int         cyc = 0, acc_cyc = 0;
  bit         wait_first = 0, ready_rand = 0, random_gaps = 0, held = 0, ok;
  int         prev_data, prev_idx;
  logic [7:0] blk [4];
  int         exp_blk [4];

  logic signed [21:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 22'($signed({1'b0, mult_a}) * $signed(mult_b));
    for (int unsigned i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_p = mpipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int model(input int k);
    int a = 0;
    for (int n = 0; n < 4; n++) a += int'(blk[n]) * C_TB[k*4 + n];
`ifdef DCT_ROUND_EN
    a += 512;
`endif
    return a >>> 10;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || clr) begin
      held = 0;
    end else begin
      if (out_valid && wait_first) begin
        chk("first_valid_latency", cyc - acc_cyc, 16 + LAT);
        wait_first = 0;
      end
      if (held && out_valid) begin
        chk("hold_data", int'(out_data), prev_data);
        chk("hold_idx", int'(out_idx), prev_idx);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got idx %0d data %0d, required none", out_idx, out_data);
        end else begin
          mon_e = q.pop_front();
          chk("out_data", int'(out_data), mon_e.data);
          chk("out_idx", int'(out_idx), mon_e.idx);
          chk("out_last", int'(out_last), int'(mon_e.idx == 3));
        end
        held = 0;
      end else if (out_valid) begin
        held      = 1;
        prev_data = int'(out_data);
        prev_idx  = int'(out_idx);
      end else begin
        held = 0;
      end
    end
  end

  task automatic send_sample(input logic [7:0] d);
    bit hs = 0;
    int n  = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 500);
    in_valid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL in_handshake: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic send_block(input bit use_model);
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      if (random_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_sample(blk[n]);
    end
    acc_cyc    = cyc;
    wait_first = 1;
    for (int k = 0; k < 4; k++) begin
      e.data = use_model ? model(k) : exp_blk[k];
      e.idx  = k;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || !in_ready) && n < 400);
    if (q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results pending, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output bit found);
    int n = 0;
    found = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    found = out_valid;
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL out_valid_wait: got 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_mult_a", int'(mult_a), 0);
    chk("rst_mult_b", int'(mult_b), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    blk = '{8'd100, 8'd100, 8'd100, 8'd100};
    exp_blk = '{200, 0, 0, 0};
    send_block(0);
    wait_drain();

    blk = '{8'd0, 8'd1, 8'd2, 8'd3};
`ifdef DCT_ROUND_EN
    exp_blk = '{3, -2, 0, 0};
`else
    exp_blk = '{3, -3, 0, -1};
`endif
    send_block(0);
    wait_drain();

    blk = '{8'd255, 8'd255, 8'd255, 8'd255};
    exp_blk = '{510, 0, 0, 0};
    send_block(0);
    wait_drain();

    // Stall at idx 1 for ten cycles.
    for (int n = 0; n < 4; n++) blk[n] = 8'($urandom_range(0, 255));
    out_ready = 1'b0;
    send_block(1);
    wait_out_valid(ok);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_idx", int'(out_idx), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // clr beats a same-cycle sample handshake.
    in_valid = 1'b1; in_data = 8'd77; clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;

    // clr during COMPUTE op 7.
    for (int n = 0; n < 4; n++) blk[n] = 8'($urandom_range(1, 255));
    send_block(1);
    repeat (7) @(posedge clk);
    #1 clr = 1'b1;
    q.delete();
    wait_first = 0;
    @(negedge clk);
    chk("op7_mult_a", int'(mult_a), int'(blk[3]));
    chk("op7_mult_b", int'($signed(mult_b)), -669);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("post_clr_busy", int'(busy), 0);
    chk("post_clr_in_ready", int'(in_ready), 1);
    chk("post_clr_mult_b", int'(mult_b), 0);
    @(posedge clk); #1;
    blk = '{8'd10, 8'd20, 8'd30, 8'd40};
`ifdef DCT_ROUND_EN
    exp_blk = '{50, -22, 0, -2};
`else
    exp_blk = '{50, -23, 0, -2};
`endif
    send_block(0);
    wait_drain();

    ready_rand = 1; random_gaps = 1;
    repeat (20) begin
      for (int n = 0; n < 4; n++) blk[n] = 8'($urandom_range(0, 255));
      send_block(1);
    end
    wait_drain();
    ready_rand = 0; random_gaps = 0; out_ready = 1'b1;

    // Asynchronous reset while a result is being presented.
    blk = '{8'd255, 8'd255, 8'd255, 8'd255};
    out_ready = 1'b0;
    send_block(1);
    wait_out_valid(ok);
    #2 rst_n = 1'b0;
    q.delete();
    wait_first = 0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_idx", int'(out_idx), 0);
    chk("arst_out_last", int'(out_last), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int n = 0; n < 4; n++) blk[n] = 8'($urandom_range(0, 255));
    send_block(1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 time units, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dct4_mac_scheduler.md
# dct4_mac_scheduler

Sequencing controller for the 4-point 1D DCT datapath. It collects four 8-bit samples over a valid/ready stream and time-multiplexes a single external pipelined multiplier across all 16 sample×coefficient products. It accumulates each row of four products and emits the four DCT coefficients in order over a valid/ready output stream. It replaces the ad-hoc FIFO/RAM/adder-tree sequencing, so the multiplier becomes the only shared arithmetic resource.

## Interface
- MULT_LAT, 1 — external multiplier latency in cycles; legal range 1..4.
- OUT_W, 12 — signed output width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort; discards buffered samples, pipeline contents and results
- in_valid  in  1  sample valid
- in_ready  out  1  sample accept; high only in LOAD with clr low
- in_data  in  8  unsigned sample
- mult_a  out  8  multiplier operand A (sample)
- mult_b  out  14  multiplier operand B, signed Q10 coefficient
- mult_p  in  22  signed product, valid MULT_LAT cycles after operands are presented
- out_valid  out  1  coefficient valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  signed DCT coefficient
- out_idx  out  2  coefficient index k
- out_last  out  1  high with out_idx==3
- busy  out  1  high in COMPUTE, FLUSH, EMIT

## Operation
- States:
  - LOAD (reset state): accept samples x0..x3 into a sample register file at slot cnt[1:0]. The 4th handshake moves to COMPUTE.
  - COMPUTE: op counter i = 0..15, one op per cycle. Drives mult_a = x[i[1:0]] and mult_b = C[i[3:2]][i[1:0]]. After i==15, go to FLUSH.
  - FLUSH: wait until the tag pipeline is empty, then go to EMIT.
  - EMIT: present res[0..3] in order. Each out handshake advances the index. The handshake at idx 3 returns to LOAD.
- Coefficients (Q10):
  - row0: 512, 512, 512, 512
  - row1: 669, 277, −277, −669
  - row2: 512, −512, −512, 512
  - row3: 277, −669, 669, −277
- Tag pipeline: MULT_LAT stages, each carrying {valid, first_of_row, last_of_row, k}, aligned with mult_p.
- Accumulator: 24-bit signed.
  - On first_of_row: acc = sext(mult_p).
  - Otherwise: acc += sext(mult_p).
  - On last_of_row: res[k] = scale(acc_next).
- scale: arithmetic right shift by 10, with rounding per Configuration; result narrowed to OUT_W. Range is ±510, so no saturation is needed.
- mult_a and mult_b are 0 outside COMPUTE.
- clr:
  - In any state, clr returns to LOAD next cycle and zeroes cnt, the tag valids and out_valid.
  - clr wins over a same-cycle in or out handshake; that sample or result is dropped.
- Reset mid-operation: all state cleared asynchronously; outputs take reset values immediately.

## Timing
- Reset values:
  - in_ready = 1, busy = 0.
  - out_valid, out_data, out_idx, out_last = 0.
  - mult_a, mult_b = 0.
- Op i is presented in the i-th cycle after the edge accepting x3.
- out_valid first rises in the cycle after edge 16+MULT_LAT, counted from the x3-accept edge (17 cycles for MULT_LAT=1).
- out_data, out_idx and out_last are held stable while out_valid && !out_ready.
- With out_ready held high, four results appear on consecutive cycles.
- in_ready returns high the cycle after the idx-3 handshake.
- Throughput: 4 + 16 + MULT_LAT + 4 cycles per block with no stalls.
- No overlap of LOAD with COMPUTE or EMIT.

## Configuration
- DCT_ROUND_EN defined: scale = (acc + 512) >>> 10, i.e. round half up.
- DCT_ROUND_EN undefined: scale = acc >>> 10, i.e. floor truncation.

## Structure
- Package dct_pkg holds:
  - SAMPLE_W = 8, COEF_W = 14, PROD_W = 22, ACC_W = 24, Q_FRAC = 10
  - the state enum {LOAD, COMPUTE, FLUSH, EMIT}
  - the 16-entry coefficient constant array
- Sub-module dct4_coef_rom: combinational ROM, 4-bit op index → 14-bit coefficient.
- The top level holds the FSM, tag pipeline, accumulator and result registers.

## Test plan
- Samples 100,100,100,100, out_ready=1 → outputs 200, 0, 0, 0 with idx 0..3; out_last only on idx 3.
- Samples 0,1,2,3:
  - with DCT_ROUND_EN → 3, −2, 0, 0
  - without DCT_ROUND_EN → 3, −3, 0, −1
- Samples 255×4 → 510, 0, 0, 0; MULT_LAT=3 → first out_valid exactly 19 cycles after the x3 accept.
- out_ready low for 10 cycles at idx 1 → out_valid held, out_data/out_idx stable, in_ready=0, no result lost.
- clr pulse during COMPUTE op 7, then samples 10,20,30,40 → no stale output; results 50, −22, 0, −2.
- rst_n asserted during EMIT → all outputs zero immediately; in_ready=1 after release.
